mac_tx_frame_build: RTL and testbench

//  Upstream neighbour of the MAC TX CRC/preamble stage. Takes a header request (dest MAC, EtherType) plus an
//  AXI-Stream byte payload and emits one complete Ethernet frame without preamble/FCS:
//  DA(6) SA(6) TYPE(2) payload, zero-padded to MIN_PAYLOAD and truncated at MAX_PAYLOAD. Output feeds mac_tdata_in.

---
 rtl/mac_tx_frame_build.sv | 202 ++++++++++++++++++++
 tb/tb_mac_tx_frame_build.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_frame_build.sv
// Ethernet TX frame builder: prepends DA/SA/EtherType to an AXI-Stream byte
// payload, zero-pads short payloads and truncates oversize ones. Output is a
// registered AXI-Stream byte stage feeding the CRC/preamble stage.
module mac_tx_frame_build #(
  parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_00_00_01,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic        hdr_valid_in,
  output logic        hdr_ready_out,
  input  logic [47:0] hdr_dst_mac_in,
  input  logic [15:0] hdr_type_in,
  input  logic [7:0]  s_tdata_in,
  input  logic        s_tvalid_in,
  output logic        s_tready_out,
  input  logic        s_tlast_in,
  output logic [7:0]  mac_tdata_out,
  output logic        mac_tvalid_out,
  input  logic        mac_tready_in,
  output logic        mac_tlast_out,
  output logic        frame_done_out,
  output logic        oversize_out,
  output logic        busy_out
);

  localparam int unsigned CNT_W     = 11;
  localparam int unsigned BCNT_W    = 4;
  localparam int unsigned HDR_LAST  = 13;
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [BCNT_W-1:0] HDR_LAST_CNT = BCNT_W'(HDR_LAST);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_PAD  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [47:0]        dst_q, dst_d;
  logic [15:0]        type_q, type_d;
  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [7:0]         tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               busy_q;
  logic               run_q;

  logic               adv;
  logic [111:0]       hdr_word;
  logic [6:0]         hdr_lsb;
  logic [7:0]         hdr_byte;
  logic [CNT_W-1:0]   pay_inc;

  // Output stage can take a new byte when empty or when its byte is leaving.
  always_comb begin
    adv      = !tvalid_q || mac_tready_in;
    hdr_word = {dst_q, LOCAL_MAC, type_q};
    hdr_lsb  = 7'd104 - {byte_cnt_q, 3'b000};
    hdr_byte = hdr_word[hdr_lsb +: 8];
    pay_inc  = pay_cnt_q + 11'd1;
  end

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d       = state_q;
    dst_d         = dst_q;
    type_d        = type_q;
    byte_cnt_d    = byte_cnt_q;
    pay_cnt_d     = pay_cnt_q;
    tdata_d       = tdata_q;
    tvalid_d      = adv ? 1'b0 : tvalid_q;
    tlast_d       = adv ? 1'b0 : tlast_q;
    ovr_d         = 1'b0;
    done_d        = tvalid_q && mac_tready_in && tlast_q;
    hdr_ready_out = 1'b0;
    s_tready_out  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Ready only once the previous frame's last byte has left or is leaving.
        hdr_ready_out = run_q && adv;
        if (hdr_valid_in && hdr_ready_out) begin
          dst_d      = hdr_dst_mac_in;
          type_d     = hdr_type_in;
          pay_cnt_d  = '0;
          // First DA byte goes out directly so it appears the next cycle.
          tdata_d    = hdr_dst_mac_in[47:40];
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          byte_cnt_d = BCNT_W'(1);
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        if (adv) begin
          tdata_d    = hdr_byte;
          tvalid_d   = 1'b1;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == HDR_LAST_CNT) begin
            state_d = ST_PAY;
          end
        end
      end

      ST_PAY: begin
        s_tready_out = adv;
        if (s_tvalid_in && adv) begin
          tdata_d   = s_tdata_in;
          tvalid_d  = 1'b1;
          pay_cnt_d = pay_inc;
          if (s_tlast_in) begin
            if (pay_inc >= MIN_CNT) begin
              tlast_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PAD;
            end
          end else if (pay_inc == MAX_CNT) begin
            tlast_d = 1'b1;
            ovr_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
      end

      ST_PAD: begin
        if (adv) begin
          tdata_d   = 8'h00;
          tvalid_d  = 1'b1;
          pay_cnt_d = pay_inc;
          if (pay_inc >= MIN_CNT) begin
            tlast_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        // Swallow the rest of an oversize payload.
        s_tready_out = 1'b1;
        if (s_tvalid_in && s_tlast_in) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      type_q     <= '0;
      byte_cnt_q <= '0;
      pay_cnt_q  <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      type_q     <= type_d;
      byte_cnt_q <= byte_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      busy_q     <= (state_d != ST_IDLE);
      run_q      <= 1'b1;
    end
  end

  // Registered outputs.
  always_comb begin
    mac_tdata_out  = tdata_q;
    mac_tvalid_out = tvalid_q;
    mac_tlast_out  = tlast_q;
    frame_done_out = done_q;
    oversize_out   = ovr_q;
    busy_out       = busy_q;
  end

endmodule

// File: tb/tb_mac_tx_frame_build.sv
// Directed bench for mac_tx_frame_build: header insertion, padding,
// truncation, stalls, mid-frame reset and back-to-back frames.
module tb_mac_tx_frame_build;

  localparam int BUDGET = 6000;

  logic        logic_clk = 1'b0;
  logic        logic_rst_n;
  logic        hdr_valid_in;
  logic        hdr_ready_out;
  logic [47:0] hdr_dst_mac_in;
  logic [15:0] hdr_type_in;
  logic [7:0]  s_tdata_in;
  logic        s_tvalid_in;
  logic        s_tready_out;
  logic        s_tlast_in;
  logic [7:0]  mac_tdata_out;
  logic        mac_tvalid_out;
  logic        mac_tready_in;
  logic        mac_tlast_out;
  logic        frame_done_out;
  logic        oversize_out;
  logic        busy_out;

  mac_tx_frame_build dut (
    .logic_clk      (logic_clk),
    .logic_rst_n    (logic_rst_n),
    .hdr_valid_in   (hdr_valid_in),
    .hdr_ready_out  (hdr_ready_out),
    .hdr_dst_mac_in (hdr_dst_mac_in),
    .hdr_type_in    (hdr_type_in),
    .s_tdata_in     (s_tdata_in),
    .s_tvalid_in    (s_tvalid_in),
    .s_tready_out   (s_tready_out),
    .s_tlast_in     (s_tlast_in),
    .mac_tdata_out  (mac_tdata_out),
    .mac_tvalid_out (mac_tvalid_out),
    .mac_tready_in  (mac_tready_in),
    .mac_tlast_out  (mac_tlast_out),
    .frame_done_out (frame_done_out),
    .oversize_out   (oversize_out),
    .busy_out       (busy_out)
  );

  always #5 logic_clk = ~logic_clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         cyc;
  } beat_t;

  beat_t outq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int last_cnt, done_cnt, ovr_cnt, pad_rdy, drop_waits;
  bit pay_sent;
  bit stall_prev = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;

  // Output monitor: records transfers, pulses, and checks stall stability.
  always @(negedge logic_clk) begin
    cyc++;
    if (logic_rst_n) begin
      if (hdr_valid_in && hdr_ready_out) hs_cyc = cyc;
      if (mac_tvalid_out && mac_tready_in) begin
        outq.push_back('{d: mac_tdata_out, l: mac_tlast_out, cyc: cyc});
        if (mac_tlast_out) last_cnt++;
      end
      if (frame_done_out) done_cnt++;
      if (oversize_out) ovr_cnt++;
      if (pay_sent && s_tready_out) pad_rdy++;
      if (stall_prev) begin
        total++;
        if (mac_tvalid_out !== 1'b1 || mac_tdata_out !== prev_d || mac_tlast_out !== prev_l) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   mac_tvalid_out, mac_tdata_out, mac_tlast_out, prev_d, prev_l);
        end
      end
      stall_prev = mac_tvalid_out && !mac_tready_in;
      prev_d = mac_tdata_out;
      prev_l = mac_tlast_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Index of first byte of a frame at outq[off..] that differs from the expected frame, or -1.
  function automatic int first_bad(input int off, input logic [47:0] dst, input logic [15:0] typ,
                                   input int len, input logic [7:0] base);
    logic [47:0] sa;
    logic [7:0]  e;
    int          n;
    int          k;
    sa = 48'h00_0A_35_00_00_01;
    n  = 14 + ((len < 46) ? 46 : ((len > 1500) ? 1500 : len));
    for (int i = 0; i < n; i++) begin
      if (i < 6)       e = dst[8*(5-i) +: 8];
      else if (i < 12) e = sa[8*(11-i) +: 8];
      else if (i < 14) e = typ[8*(13-i) +: 8];
      else begin
        k = i - 14;
        e = (k < len) ? 8'(int'(base) + k) : 8'h00;
      end
      if (off + i >= outq.size()) return i;
      if (outq[off+i].d !== e || outq[off+i].l !== (i == n - 1)) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge logic_clk);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ, input int len,
                            input logic [7:0] base, input bit gaps);
    bit hs;
    bit acc;
    int g;
    hdr_dst_mac_in = dst;
    hdr_type_in    = typ;
    hdr_valid_in   = 1'b1;
    hs = 1'b0;
    g  = 0;
    while (!hs && g < BUDGET) begin
      @(negedge logic_clk);
      hs = hdr_ready_out;
      step();
      g++;
    end
    hdr_valid_in = 1'b0;
    total++;
    if (!hs) begin
      bad++;
      $display("FAIL hdr_timeout: got no handshake want handshake within %0d cycles", BUDGET);
      return;
    end
    for (int k = 0; k < len; k++) begin
      s_tdata_in = 8'(int'(base) + k);
      s_tlast_in = (k == len - 1);
      acc = 1'b0;
      g   = 0;
      while (!acc && g < BUDGET) begin
        s_tvalid_in = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge logic_clk);
        acc = s_tvalid_in && s_tready_out;
        if (s_tvalid_in && !s_tready_out && k >= 1500) drop_waits++;
        step();
        g++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL pay_timeout: got stuck at byte %0d want accepted", k);
        s_tvalid_in = 1'b0;
        return;
      end
    end
    s_tvalid_in = 1'b0;
    s_tlast_in  = 1'b0;
    pay_sent    = 1'b1;
  endtask

  task automatic run_frame(input logic [47:0] dst, input logic [15:0] typ, input int len,
                           input logic [7:0] base, input bit rnd, input int nfr,
                           input logic [47:0] dst2, input logic [15:0] typ2, input int len2,
                           input logic [7:0] base2);
    outq.delete();
    last_cnt = 0; done_cnt = 0; ovr_cnt = 0; pad_rdy = 0; drop_waits = 0; pay_sent = 1'b0;
    fork
      begin
        send_frame(dst, typ, len, base, rnd);
        if (nfr > 1) send_frame(dst2, typ2, len2, base2, rnd);
      end
      begin
        int g;
        g = 0;
        while (last_cnt < nfr && g < BUDGET) begin
          mac_tready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          step();
          g++;
        end
        mac_tready_in = 1'b1;
        total++;
        if (last_cnt < nfr) begin
          bad++;
          $display("FAIL out_timeout: got %0d tlast want %0d", last_cnt, nfr);
        end
      end
    join
    repeat (4) step();
  endtask

  task automatic test_reset();
    logic_rst_n = 1'b1;
    hdr_valid_in = 1'b0; hdr_dst_mac_in = '0; hdr_type_in = '0;
    s_tdata_in = '0; s_tvalid_in = 1'b0; s_tlast_in = 1'b0; mac_tready_in = 1'b1;
    #2 logic_rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({mac_tvalid_out, mac_tlast_out, frame_done_out, oversize_out, busy_out,
         hdr_ready_out, s_tready_out} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000", {mac_tvalid_out, mac_tlast_out,
               frame_done_out, oversize_out, busy_out, hdr_ready_out, s_tready_out});
    end
    total++;
    if (mac_tdata_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h want 00", mac_tdata_out);
    end
    logic_rst_n = 1'b1;
    repeat (2) step();
    total++;
    if (hdr_ready_out !== 1'b1 || busy_out !== 1'b0 || s_tready_out !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got hr=%b busy=%b sr=%b want hr=1 busy=0 sr=0",
               hdr_ready_out, busy_out, s_tready_out);
    end
  endtask

  task automatic test_basic();
    int fb;
    run_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, 8'h00, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, 8'h00);
    total++;
    if (outq.size() !== 78) begin bad++; $display("FAIL basic_len: got %0d want 78", outq.size()); end
    total++;
    if (fb !== -1) begin bad++; $display("FAIL basic_bytes: got bad index %0d want -1", fb); end
    total++;
    if (done_cnt !== 1 || ovr_cnt !== 0) begin
      bad++; $display("FAIL basic_pulses: got done=%0d ovr=%0d want done=1 ovr=0", done_cnt, ovr_cnt);
    end
    total++;
    if (outq.size() == 0 || outq[0].cyc !== hs_cyc + 1) begin
      bad++; $display("FAIL basic_latency: got first byte cycle %0d want %0d",
                      (outq.size() == 0) ? -1 : outq[0].cyc, hs_cyc + 1);
    end
  endtask

  task automatic test_pad();
    int fb;
    run_frame(48'h01_02_03_04_05_06, 16'h0806, 10, 8'hA0, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'h01_02_03_04_05_06, 16'h0806, 10, 8'hA0);
    total++;
    if (outq.size() !== 60) begin bad++; $display("FAIL pad_len: got %0d want 60", outq.size()); end
    total++;
    if (fb !== -1) begin bad++; $display("FAIL pad_bytes: got bad index %0d want -1", fb); end
    total++;
    if (pad_rdy !== 0) begin bad++; $display("FAIL pad_sready: got %0d ready cycles want 0", pad_rdy); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL pad_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_min_max();
    int fb;
    run_frame(48'h10_20_30_40_50_60, 16'h88CC, 46, 8'h11, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'h10_20_30_40_50_60, 16'h88CC, 46, 8'h11);
    total++;
    if (outq.size() !== 60 || fb !== -1) begin
      bad++; $display("FAIL min_frame: got len=%0d bad=%0d want len=60 bad=-1", outq.size(), fb);
    end
    run_frame(48'hAA_BB_CC_DD_EE_01, 16'h0800, 1500, 8'h00, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'hAA_BB_CC_DD_EE_01, 16'h0800, 1500, 8'h00);
    total++;
    if (outq.size() !== 1514 || fb !== -1) begin
      bad++; $display("FAIL max_frame: got len=%0d bad=%0d want len=1514 bad=-1", outq.size(), fb);
    end
    total++;
    if (ovr_cnt !== 0 || done_cnt !== 1) begin
      bad++; $display("FAIL max_pulses: got ovr=%0d done=%0d want ovr=0 done=1", ovr_cnt, done_cnt);
    end
  endtask

  task automatic test_oversize();
    int fb;
    run_frame(48'h02_00_00_00_00_99, 16'h0800, 1600, 8'h00, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'h02_00_00_00_00_99, 16'h0800, 1600, 8'h00);
    total++;
    if (outq.size() !== 1514 || fb !== -1) begin
      bad++; $display("FAIL over_frame: got len=%0d bad=%0d want len=1514 bad=-1", outq.size(), fb);
    end
    total++;
    if (ovr_cnt !== 1 || done_cnt !== 1) begin
      bad++; $display("FAIL over_pulses: got ovr=%0d done=%0d want ovr=1 done=1", ovr_cnt, done_cnt);
    end
    total++;
    if (drop_waits !== 0) begin bad++; $display("FAIL over_drain: got %0d stalls want 0", drop_waits); end
    run_frame(48'h00_11_22_33_44_55, 16'h0800, 64, 8'h30, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'h00_11_22_33_44_55, 16'h0800, 64, 8'h30);
    total++;
    if (outq.size() !== 78 || fb !== -1 || ovr_cnt !== 0) begin
      bad++; $display("FAIL after_over: got len=%0d bad=%0d ovr=%0d want len=78 bad=-1 ovr=0",
                      outq.size(), fb, ovr_cnt);
    end
  endtask

  task automatic test_stall();
    int fb;
    run_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, 8'h00, 1'b1, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'hFF_FF_FF_FF_FF_FF, 16'h0800, 64, 8'h00);
    total++;
    if (outq.size() !== 78 || fb !== -1) begin
      bad++; $display("FAIL stall_frame: got len=%0d bad=%0d want len=78 bad=-1", outq.size(), fb);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int k;
    int g;
    int fb;
    bit hs;
    outq.delete();
    done_cnt = 0;
    mac_tready_in  = 1'b1;
    hdr_dst_mac_in = 48'h02_11_22_33_44_55;
    hdr_type_in    = 16'h88B5;
    hdr_valid_in   = 1'b1;
    hs = 1'b0;
    g  = 0;
    while (!hs && g < BUDGET) begin
      @(negedge logic_clk);
      hs = hdr_ready_out;
      step();
      g++;
    end
    hdr_valid_in = 1'b0;
    k = 0;
    g = 0;
    while (k < 20 && g < BUDGET) begin
      s_tvalid_in = 1'b1;
      s_tdata_in  = 8'(k);
      s_tlast_in  = 1'b0;
      @(negedge logic_clk);
      if (s_tready_out) k++;
      step();
      g++;
    end
    total++;
    if (k !== 20 || mac_tvalid_out !== 1'b1) begin
      bad++; $display("FAIL rst_mid_setup: got k=%0d v=%b want k=20 v=1", k, mac_tvalid_out);
    end
    logic_rst_n = 1'b0;
    #2;
    total++;
    if (mac_tvalid_out !== 1'b0 || busy_out !== 1'b0 || mac_tlast_out !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async: got v=%b busy=%b l=%b want 0 0 0",
                      mac_tvalid_out, busy_out, mac_tlast_out);
    end
    s_tvalid_in = 1'b0;
    repeat (2) step();
    logic_rst_n = 1'b1;
    repeat (2) step();
    total++;
    if (outq.size() !== 33 || done_cnt !== 0) begin
      bad++; $display("FAIL rst_mid_partial: got len=%0d done=%0d want len=33 done=0",
                      outq.size(), done_cnt);
    end
    run_frame(48'h0A_0B_0C_0D_0E_0F, 16'h86DD, 50, 8'h40, 1'b0, 1, '0, '0, 0, '0);
    fb = first_bad(0, 48'h0A_0B_0C_0D_0E_0F, 16'h86DD, 50, 8'h40);
    total++;
    if (outq.size() !== 64 || fb !== -1 || done_cnt !== 1) begin
      bad++; $display("FAIL rst_mid_next: got len=%0d bad=%0d done=%0d want len=64 bad=-1 done=1",
                      outq.size(), fb, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int fb1;
    int fb2;
    int span;
    run_frame(48'h66_55_44_33_22_11, 16'h0800, 64, 8'h80, 1'b0, 2,
              48'h12_34_56_78_9A_BC, 16'h0842, 10, 8'h05);
    fb1 = first_bad(0, 48'h66_55_44_33_22_11, 16'h0800, 64, 8'h80);
    fb2 = first_bad(78, 48'h12_34_56_78_9A_BC, 16'h0842, 10, 8'h05);
    total++;
    if (outq.size() !== 138 || fb1 !== -1 || fb2 !== -1) begin
      bad++; $display("FAIL b2b_bytes: got len=%0d bad1=%0d bad2=%0d want len=138 bad=-1",
                      outq.size(), fb1, fb2);
    end
    span = (outq.size() > 0) ? outq[outq.size()-1].cyc - outq[0].cyc : -1;
    total++;
    if (span !== 137) begin bad++; $display("FAIL b2b_gap: got span %0d want 137", span); end
    total++;
    if (done_cnt !== 2) begin bad++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_min_max();
    test_oversize();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
